// File: rtl/wb_responder.sv
// Wishbone register block (CSR/DPR/CMDR/FSMR) with programmable wait states
// and a fixed-duration command engine that raises a registered interrupt.
module wb_responder #(
    parameter int ADDR_WIDTH  = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_STATES = 1,
    parameter int CMD_CYCLES  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  ack_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  irq_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic                  r_ack;
    logic [3:0]            r_wait;
    logic [DATA_WIDTH-1:0] r_dat;
    logic                  r_e;
    logic                  r_ie;
    logic                  r_don;
    logic                  r_err;
    logic                  r_irq;
    logic [2:0]            r_cmd;
    logic [7:0]            r_dpr;
    logic [7:0]            r_count;

    logic       w_req;
    logic       w_acc;
    logic [1:0] w_adr;
    logic       w_csr_wr;
    logic       w_dpr_wr;
    logic       w_cmd_wr;
    logic       w_cmd_rd;
    logic       w_start;
    logic       w_abort;
    logic       w_finish;
    logic       w_busy;
    logic [7:0] w_fsmr;
    logic [7:0] w_rd8;
    logic       w_unused;

    assign w_req = cyc_i & stb_i;
    assign w_adr = adr_i[1:0];

    // The access happens on the edge that raises ack; the request must have
    // been held on every edge since it was first seen.
    assign w_acc    = w_req & ~r_ack & (r_wait == 4'(WAIT_STATES));
    assign w_csr_wr = w_acc &  we_i & (w_adr == 2'd0);
    assign w_dpr_wr = w_acc &  we_i & (w_adr == 2'd1);
    assign w_cmd_wr = w_acc &  we_i & (w_adr == 2'd2);
    assign w_cmd_rd = w_acc & ~we_i & (w_adr == 2'd2);

    assign w_start  = w_cmd_wr & r_e & ~w_busy;
    assign w_abort  = w_csr_wr & ~dat_i[7] & w_busy;
    assign w_finish = w_busy & ~w_abort & (r_count == 8'd1);

    assign w_unused = &{1'b0, adr_i, dat_i};

    // Bus handshake: a request seen while ack is high is ignored, so the
    // next transfer starts counting one cycle after the ack cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ack  <= 1'b0;
            r_wait <= '0;
        end else if (r_ack || !w_req) begin
            r_ack  <= 1'b0;
            r_wait <= '0;
        end else if (w_acc) begin
            r_ack  <= 1'b1;
            r_wait <= '0;
        end else begin
            r_wait <= r_wait + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) w_state_nx = S_BUSY;
            end
            S_BUSY: begin
                if (w_abort)                 w_state_nx = S_IDLE;
                else if (r_count == 8'd1)    w_state_nx = S_DONE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_fsmr = 8'h00;
        case (r_state)
            S_BUSY: begin
                w_busy = 1'b1;
                w_fsmr = 8'h10;
            end
            S_DONE:  w_fsmr = 8'h20;
            default: w_fsmr = 8'h00;
        endcase
    end

    always_comb begin
        w_rd8 = 8'h00;
        case (w_adr)
            2'd0:    w_rd8 = {r_e, r_ie, 6'b000000};
            2'd1:    w_rd8 = r_dpr;
            2'd2:    w_rd8 = {r_don, 1'b0, 1'b0, r_err, 1'b0, r_cmd};
            default: w_rd8 = w_fsmr;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (w_start) begin
            r_count <= 8'(CMD_CYCLES);
        end else if (w_abort) begin
            r_count <= '0;
        end else if (w_busy && r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_e   <= 1'b0;
            r_ie  <= 1'b0;
            r_dpr <= '0;
            r_cmd <= '0;
            r_don <= 1'b0;
            r_err <= 1'b0;
            r_irq <= 1'b0;
            r_dat <= '0;
        end else begin
            if (w_csr_wr) begin
                r_e  <= dat_i[7];
                r_ie <= dat_i[6];
            end
            if (w_dpr_wr) r_dpr <= dat_i[7:0];
            if (w_start) begin
                r_cmd <= dat_i[2:0];
                r_don <= 1'b0;
                r_err <= 1'b0;
            end else if (w_finish) begin
                if (r_cmd <= 3'd5) r_don <= 1'b1;
                else               r_err <= 1'b1;
            end
            // Completion takes priority over any same-edge clear.
            if (w_finish && r_ie) begin
                r_irq <= 1'b1;
            end else if (w_start || w_cmd_rd || w_abort || (w_csr_wr && !dat_i[6])) begin
                r_irq <= 1'b0;
            end
            r_dat <= (w_acc && !we_i) ? DATA_WIDTH'(w_rd8) : '0;
        end
    end

    assign ack_o = r_ack;
    assign dat_o = r_dat;
    assign irq_o = r_irq;

endmodule

// File: tb/tb_wb_responder.sv
// Randomized bench for wb_responder: a transaction-level model keyed on edge
// numbers predicts read data, ack latency and the interrupt line.
module tb_wb_responder;

    localparam int WS  = 3;
    localparam int CMD = 16;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [7:0]    dat_i;
    logic          ack;
    logic [7:0]    dat_o;
    logic          irq;

    wb_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (8),
        .WAIT_STATES(WS),
        .CMD_CYCLES (CMD)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .cyc_i(cyc),
        .stb_i(stb),
        .we_i (we),
        .adr_i(adr),
        .dat_i(dat_i),
        .ack_o(ack),
        .dat_o(dat_o),
        .irq_o(irq)
    );

    always #5 clk = ~clk;

    int unsigned edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
    endtask

    // Model: a command started at edge S completes at edge S+CMD.
    bit          m_e, m_ie, m_busy, m_done, m_don, m_err, m_irq;
    bit   [2:0]  m_cmd;
    bit   [7:0]  m_dpr;
    int unsigned m_start;

    task automatic m_reset();
        m_e = 0; m_ie = 0; m_busy = 0; m_done = 0; m_don = 0; m_err = 0;
        m_irq = 0; m_cmd = 0; m_dpr = 0; m_start = 0;
    endtask

    task automatic m_finish(input bit ie);
        m_busy = 0;
        m_done = 1;
        if (m_cmd <= 3'd5) m_don = 1;
        else               m_err = 1;
        if (ie) m_irq = 1;
    endtask

    task automatic m_settle(input int unsigned last_edge);
        if (m_busy && (m_start + CMD <= last_edge)) m_finish(m_ie);
    endtask

    function automatic logic [7:0] m_read(input bit [1:0] a);
        case (a)
            2'd0:    return {m_e, m_ie, 6'b0};
            2'd1:    return m_dpr;
            2'd2:    return {m_don, 2'b00, m_err, 1'b0, m_cmd};
            default: return m_busy ? 8'h10 : (m_done ? 8'h20 : 8'h00);
        endcase
    endfunction

    task automatic m_access(input int unsigned t, input bit w, input bit [1:0] a,
                            input bit [7:0] d, output logic [7:0] rexp);
        bit comp_now, ie_pre, e_pre;
        m_settle(t - 1);
        rexp     = w ? 8'h00 : m_read(a);
        comp_now = m_busy && (m_start + CMD == t);
        ie_pre   = m_ie;
        e_pre    = m_e;
        if (w) begin
            case (a)
                2'd0: begin
                    m_e = d[7];
                    m_ie = d[6];
                    if (!d[6]) m_irq = 0;
                    if (!d[7] && m_busy) begin
                        m_busy = 0; m_done = 0; comp_now = 0; m_irq = 0;
                    end
                end
                2'd1: m_dpr = d;
                2'd2: if (e_pre && !m_busy) begin
                    m_busy = 1; m_done = 0; m_start = t; m_cmd = d[2:0];
                    m_don = 0; m_err = 0; m_irq = 0;
                end
                default: ;
            endcase
        end else if (a == 2'd2) begin
            m_irq = 0;
        end
        if (comp_now) m_finish(ie_pre);
    endtask

    task automatic idle(input int unsigned g);
        repeat (g) begin @(posedge clk); #1; end
    endtask

    task automatic check_irq();
        m_settle(edge_n);
        chk("irq", {31'b0, irq}, {31'b0, m_irq});
    endtask

    // Holds the request for reps acks; later reps exercise back-to-back timing.
    task automatic xfer(input bit w, input bit [1:0] a, input bit [7:0] d, input int unsigned reps);
        logic [7:0]  rexp;
        logic [1:0]  hi;
        int unsigned n;
        hi = 2'($urandom_range(0, 3));
        cyc = 1; stb = 1; we = w; adr = {hi, a}; dat_i = d;
        for (int unsigned r = 0; r < reps; r++) begin
            n = 0;
            do begin @(posedge clk); #1; n++; end while (!ack && n < 40);
            chk("ack_latency", n, (r == 0) ? WS + 1 : WS + 2);
            if (!ack) break;
            m_access(edge_n, w, a, d, rexp);
            chk(w ? "wr_dat_o" : "rd_data", {24'b0, dat_o}, {24'b0, rexp});
        end
        cyc = 0; stb = 0; we = 0;
        @(posedge clk); #1;
        chk("ack_single", {31'b0, ack}, 32'd0);
        chk("dat_o_idle", {24'b0, dat_o}, 32'd0);
        check_irq();
    endtask

    task automatic abort_xfer(input int unsigned k, input bit drop_cyc);
        cyc = 1; stb = 1; we = 1; adr = 4'(1); dat_i = 8'($urandom);
        repeat (k) begin
            @(posedge clk); #1;
            chk("abort_no_ack", {31'b0, ack}, 32'd0);
        end
        if (drop_cyc) cyc = 0;
        else          stb = 0;
        repeat (WS + 2) begin
            @(posedge clk); #1;
            chk("abort_no_ack", {31'b0, ack}, 32'd0);
        end
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        m_reset();
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_dat", {24'b0, dat_o}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
    endtask

    initial begin
        bit [1:0] a;
        bit       w;
        bit [7:0] d;
        rst = 1; cyc = 0; stb = 0; we = 0; adr = '0; dat_i = '0;
        m_reset();
        idle(3);
        do_reset();
        for (int unsigned i = 0; i < 4; i++) xfer(0, 2'(i), 8'h00, 1);

        xfer(1, 2'd0, 8'hC0, 1);
        xfer(0, 2'd0, 8'h00, 1);
        xfer(1, 2'd2, 8'h02, 1);
        xfer(0, 2'd3, 8'h00, 1);
        idle(20); check_irq();
        xfer(0, 2'd2, 8'h00, 1);
        xfer(1, 2'd2, 8'h07, 1);
        idle(20);
        xfer(0, 2'd2, 8'h00, 1);
        xfer(1, 2'd0, 8'h40, 1);
        xfer(1, 2'd2, 8'h01, 1);
        xfer(0, 2'd3, 8'h00, 1);

        // Read ack lands exactly on the completion edge.
        xfer(1, 2'd0, 8'hC0, 1);
        xfer(1, 2'd2, 8'h05, 1);
        idle(CMD - WS - 2);
        xfer(0, 2'd2, 8'h00, 1);

        for (int unsigned k = 1; k <= WS; k++) abort_xfer(k, k[0]);
        xfer(0, 2'd1, 8'h00, 1);
        xfer(1, 2'd1, 8'h5A, 2);
        xfer(0, 2'd0, 8'h00, 3);

        xfer(1, 2'd2, 8'h03, 1);
        idle(5);
        xfer(1, 2'd0, 8'h80, 1);
        xfer(0, 2'd3, 8'h00, 1);
        xfer(1, 2'd0, 8'hC0, 1);
        xfer(1, 2'd1, 8'hA5, 1);
        xfer(1, 2'd2, 8'h04, 1);
        idle(3);
        do_reset();
        for (int unsigned i = 0; i < 4; i++) xfer(0, 2'(i), 8'h00, 1);

        for (int unsigned i = 0; i < 200; i++) begin
            a = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            if (a == 2'd0 && w) d[7] = ($urandom_range(0, 3) != 0);
            xfer(w, a, d, 1);
            idle($urandom_range(0, 24));
            check_irq();
            if ($urandom_range(0, 49) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
